// File: rtl/vdp_vram_arbiter_if.sv
// VRAM arbiter bus: three requester channels plus the SDRAM controller side.
// master = surrounding VDP core / controller, slave = the arbiter itself.
interface vdp_vram_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              scr_valid;
  logic [ADDR_W-1:0] scr_address;
  logic              scr_ready;
  logic [DATA_W-1:0] scr_rdata;
  logic              scr_rdata_en;

  logic              cpu_valid;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_en;

  logic              cmd_valid;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_rdata;
  logic              cmd_rdata_en;

  logic              dram_valid;
  logic              dram_write;
  logic [ADDR_W-1:0] dram_address;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_ready;
  logic [DATA_W-1:0] dram_rdata;
  logic              dram_rdata_en;

  logic              timeout_flag;

  modport master (
    output scr_valid, scr_address,
    input  scr_ready, scr_rdata, scr_rdata_en,
    output cpu_valid, cpu_write, cpu_address, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_rdata_en,
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  cmd_ready, cmd_rdata, cmd_rdata_en,
    input  dram_valid, dram_write, dram_address, dram_wdata,
    output dram_ready, dram_rdata, dram_rdata_en,
    input  timeout_flag
  );

  modport slave (
    input  scr_valid, scr_address,
    output scr_ready, scr_rdata, scr_rdata_en,
    input  cpu_valid, cpu_write, cpu_address, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_rdata_en,
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output cmd_ready, cmd_rdata, cmd_rdata_en,
    output dram_valid, dram_write, dram_address, dram_wdata,
    input  dram_ready, dram_rdata, dram_rdata_en,
    output timeout_flag
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: screen has fixed priority, CPU and command
// engine alternate; one transaction in flight, read timeout guard.
module vdp_vram_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset_n,
  vdp_vram_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state;
  logic [2:0]        owner;
  logic              rr_cmd;
  logic              hold;
  logic [CW-1:0]     cnt;

  logic              gnt_scr;
  logic              gnt_cpu;
  logic              gnt_cmd;
  logic              g_write;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              both;

  assign both = bus.cpu_valid && bus.cmd_valid;

  always_comb begin
    gnt_scr = 1'b0;
    gnt_cpu = 1'b0;
    gnt_cmd = 1'b0;
    if (state == S_IDLE && !hold) begin
      if (bus.scr_valid)
        gnt_scr = 1'b1;
      else if (both) begin
        gnt_cpu = !rr_cmd;
        gnt_cmd = rr_cmd;
      end else begin
        gnt_cpu = bus.cpu_valid;
        gnt_cmd = bus.cmd_valid;
      end
    end
  end

  always_comb begin
    g_write = 1'b0;
    g_addr  = bus.scr_address;
    g_wdata = '0;
    unique case (1'b1)
      gnt_cpu: begin
        g_write = bus.cpu_write;
        g_addr  = bus.cpu_address;
        g_wdata = bus.cpu_wdata;
      end
      gnt_cmd: begin
        g_write = bus.cmd_write;
        g_addr  = bus.cmd_address;
        g_wdata = bus.cmd_wdata;
      end
      default: ;
    endcase
  end

  // Returned data (or the all-ones timeout filler) goes to the owner only.
  task automatic deliver(input logic [DATA_W-1:0] d);
    unique case (1'b1)
      owner[0]: begin
        bus.scr_rdata    <= d;
        bus.scr_rdata_en <= 1'b1;
      end
      owner[1]: begin
        bus.cpu_rdata    <= d;
        bus.cpu_rdata_en <= 1'b1;
      end
      owner[2]: begin
        bus.cmd_rdata    <= d;
        bus.cmd_rdata_en <= 1'b1;
      end
      default: ;
    endcase
  endtask

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      owner             <= '0;
      rr_cmd            <= 1'b0;
      hold              <= 1'b0;
      cnt               <= '0;
      bus.scr_ready     <= 1'b0;
      bus.scr_rdata     <= '0;
      bus.scr_rdata_en  <= 1'b0;
      bus.cpu_ready     <= 1'b0;
      bus.cpu_rdata     <= '0;
      bus.cpu_rdata_en  <= 1'b0;
      bus.cmd_ready     <= 1'b0;
      bus.cmd_rdata     <= '0;
      bus.cmd_rdata_en  <= 1'b0;
      bus.dram_valid    <= 1'b0;
      bus.dram_write    <= 1'b0;
      bus.dram_address  <= '0;
      bus.dram_wdata    <= '0;
      bus.timeout_flag  <= 1'b0;
    end else begin
      bus.scr_ready    <= 1'b0;
      bus.cpu_ready    <= 1'b0;
      bus.cmd_ready    <= 1'b0;
      bus.scr_rdata_en <= 1'b0;
      bus.cpu_rdata_en <= 1'b0;
      bus.cmd_rdata_en <= 1'b0;
      hold             <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_scr || gnt_cpu || gnt_cmd) begin
            owner            <= {gnt_cmd, gnt_cpu, gnt_scr};
            bus.scr_ready    <= gnt_scr;
            bus.cpu_ready    <= gnt_cpu;
            bus.cmd_ready    <= gnt_cmd;
            bus.dram_valid   <= 1'b1;
            bus.dram_write   <= g_write;
            bus.dram_address <= g_addr;
            bus.dram_wdata   <= g_wdata;
            state            <= S_ISSUE;
            if (!gnt_scr && both)
              rr_cmd <= !rr_cmd;
          end
        end
        S_ISSUE: begin
          if (bus.dram_ready) begin
            bus.dram_valid <= 1'b0;
            cnt            <= '0;
            if (bus.dram_write) begin
              state <= S_IDLE;
              hold  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.dram_rdata_en) begin
            deliver(bus.dram_rdata);
            state <= S_IDLE;
            hold  <= 1'b1;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            deliver('1);
            bus.timeout_flag <= 1'b1;
            state            <= S_IDLE;
            hold             <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
